// File: rtl/alu.sv
// Registered 32-bit ALU: eight operations on A/B selected by ALUOp, with the
// result, zero and signed-overflow flags captured one cycle after the operands.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Overflow when both addends share a sign the sum does not.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] diff;
    logic [4:0]              shamt;
    logic                    lt;

    logic [WIDTH-1:0] res_p0;
    logic             ovf_p0;

    logic [WIDTH-1:0] c_p1;
    logic             zero_p1;
    logic             ovf_p1;

    assign a_s   = A;
    assign b_s   = B;
    assign sum   = a_s + b_s;
    assign diff  = a_s - b_s;
    assign shamt = B[4:0];
    // Direct signed compare, so a wrapped A-B never corrupts slt.
    assign lt    = (a_s < b_s);

    always_comb begin
        res_p0 = '0;
        ovf_p0 = 1'b0;
        unique case (ALUOp)
            OP_ADD: begin
                res_p0 = sum;
                ovf_p0 = add_ovf(a_s, b_s, sum);
            end
            OP_SUB: begin
                res_p0 = diff;
                ovf_p0 = sub_ovf(a_s, b_s, diff);
            end
            OP_AND: res_p0 = A & B;
            OP_OR:  res_p0 = A | B;
            OP_SRL: res_p0 = A >> shamt;
            OP_SRA: res_p0 = a_s >>> shamt;
            OP_XOR: res_p0 = A ^ B;
            OP_SLT: res_p0 = {{(WIDTH-1){1'b0}}, lt};
            default: res_p0 = '0;
        endcase
    end

    // ---- stage p0 -> p1: result register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            c_p1    <= '0;
            zero_p1 <= 1'b1;
            ovf_p1  <= 1'b0;
        end else begin
            c_p1    <= res_p0;
            zero_p1 <= (res_p0 == '0);
            ovf_p1  <= ovf_p0;
        end
    end

    assign C        = c_p1;
    assign zero     = zero_p1;
    assign overflow = ovf_p1;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: each step queues its expected result, which is
// checked against the DUT outputs on the falling edge after capture.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic [31:0] C;
    logic        zero;
    logic        overflow;

    typedef struct packed {
        logic [31:0] c;
        logic        z;
        logic        o;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .B(B),
        .ALUOp(ALUOp),
        .C(C),
        .zero(zero),
        .overflow(overflow)
    );

    // Reference model, written with wide arithmetic and bit loops.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        logic [31:0] x;
        int     n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        x  = 32'h0;
        e.o = 1'b0;
        case (op)
            3'd0: begin r = sa + sb; x = r[31:0]; e.o = (r != longint'($signed(x))); end
            3'd1: begin r = sa - sb; x = r[31:0]; e.o = (r != longint'($signed(x))); end
            3'd2: x = a & b;
            3'd3: x = a | b;
            3'd4: begin x = a; for (int i = 0; i < n; i++) x = {1'b0, x[31:1]}; end
            3'd5: begin x = a; for (int i = 0; i < n; i++) x = {x[31], x[31:1]}; end
            3'd6: x = a ^ b;
            default: x = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
        endcase
        e.c = x;
        e.z = (x == 32'h0);
        return e;
    endfunction

    task automatic check_front();
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (C === e.c) else begin
                errors++;
                $error("FAIL %s C got %h want %h", t, C, e.c);
            end
            checks++;
            assert (zero === e.z) else begin
                errors++;
                $error("FAIL %s zero got %b want %b", t, zero, e.z);
            end
            checks++;
            assert (overflow === e.o) else begin
                errors++;
                $error("FAIL %s overflow got %b want %b", t, overflow, e.o);
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] ec,
                        input logic ez, input logic eo, input string t);
        @(negedge clk);
        check_front();
        reset = r;
        A     = a;
        B     = b;
        ALUOp = op;
        exp_q.push_back(exp_t'{c: ec, z: ez, o: eo});
        tag_q.push_back(t);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        A     = 32'h0;
        B     = 32'h0;
        ALUOp = 3'b000;

        step(1'b1, 32'h12345678, 32'h9ABCDEF0, 3'b001, 32'h0, 1'b1, 1'b0, "reset");

        step(1'b0, 32'hB0DAB0DA, 32'd2, 3'b011, 32'hB0DAB0DA, 1'b0, 1'b0, "or");
        step(1'b0, 32'hB0DAB0DA, 32'd2, 3'b100, 32'h2C36AC36, 1'b0, 1'b0, "srl2");
        step(1'b0, 32'hB0DAB0DA, 32'd2, 3'b101, 32'hEC36AC36, 1'b0, 1'b0, "sra2");
        step(1'b0, 32'hB0DAB0DA, 32'hFFFFFFE0, 3'b100, 32'hB0DAB0DA, 1'b0, 1'b0, "srl0");
        step(1'b0, 32'h80000000, 32'd31, 3'b101, 32'hFFFFFFFF, 1'b0, 1'b0, "sra31");
        step(1'b0, 32'h80000000, 32'd31, 3'b100, 32'h00000001, 1'b0, 1'b0, "srl31");

        step(1'b0, 32'h7FFFFFFF, 32'd1, 3'b000, 32'h80000000, 1'b0, 1'b1, "add_ovf");
        step(1'b0, 32'h7FFFFFFF, 32'd1, 3'b000, 32'h80000000, 1'b0, 1'b1, "add_hold");
        step(1'b0, 32'd5, 32'd7, 3'b001, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_neg");
        step(1'b0, 32'd5, 32'd5, 3'b001, 32'h0, 1'b1, 1'b0, "sub_zero");
        step(1'b0, 32'h80000000, 32'd1, 3'b001, 32'h7FFFFFFF, 1'b0, 1'b1, "sub_ovf");
        step(1'b0, 32'hFFFFFFFF, 32'd1, 3'b000, 32'h0, 1'b1, 1'b0, "add_carry");

        step(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b010, 32'hF000F000, 1'b0, 1'b0, "and");
        step(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b110, 32'h0FF00FF0, 1'b0, 1'b0, "xor");
        step(1'b0, 32'hFFFFFFFF, 32'd1, 3'b111, 32'h1, 1'b0, 1'b0, "slt_neg");
        step(1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h1, 1'b0, 1'b0, "slt_wrap");
        step(1'b0, 32'd1, 32'hFFFFFFFF, 3'b111, 32'h0, 1'b1, 1'b0, "slt_false");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            e  = model(ra, rb, 3'(i % 8));
            step(1'b0, ra, rb, 3'(i % 8), e.c, e.z, e.o, $sformatf("b2b%0d", i));
        end

        step(1'b1, 32'd3, 32'd4, 3'b000, 32'h0, 1'b1, 1'b0, "rst_mid");
        step(1'b0, 32'd3, 32'd4, 3'b000, 32'd7, 1'b0, 1'b0, "after_rst");

        @(negedge clk);
        check_front();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
